// File: rtl/bp_be_stride_prefetch_gen.sv
// Expands a loop descriptor into a deduplicated, page-bounded stream of
// cache-line prefetch addresses for the D$ prefetch port.
module bp_be_stride_prefetch_gen #(
    parameter int vaddr_width_p       = 39,
    parameter int stride_width_p      = 8,
    parameter int output_range_p      = 8,
    parameter int max_prefetch_p      = 16,
    parameter int block_width_p       = 512,
    parameter int page_offset_width_p = 12
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      v_i,
    input  logic [vaddr_width_p-1:0]  pc_i,
    input  logic [vaddr_width_p-1:0]  eff_addr_i,
    input  logic [stride_width_p-1:0] stride_i,
    input  logic [output_range_p-1:0] remaining_iterations_i,
    output logic                      yumi_o,
    input  logic                      flush_i,
    output logic                      pf_v_o,
    output logic [vaddr_width_p-1:0]  pf_vaddr_o,
    output logic [vaddr_width_p-1:0]  pf_pc_o,
    input  logic                      pf_ready_and_i,
    output logic                      busy_o
);

    localparam int lg_line_lp = $clog2(block_width_p / 8);
    localparam int line_w_lp  = vaddr_width_p - lg_line_lp;
    localparam int page_w_lp  = vaddr_width_p - page_offset_width_p;
    localparam logic [output_range_p-1:0] max_lp = output_range_p'(max_prefetch_p);

    typedef enum logic {
        e_idle,
        e_issue
    } state_e;

    state_e                      r_state;
    state_e                      w_state_n;
    logic [vaddr_width_p-1:0]    r_addr;
    logic [vaddr_width_p-1:0]    r_stride;
    logic [page_w_lp-1:0]        r_page;
    logic [vaddr_width_p-1:0]    r_pc;
    logic [output_range_p-1:0]   r_cnt;
    logic                        r_last_v;
    logic [line_w_lp-1:0]        r_last_line;

    logic [vaddr_width_p-1:0]    w_stride_sext;
    logic [output_range_p-1:0]   w_cnt_clamp;
    logic [line_w_lp-1:0]        w_line;
    logic                        w_idle;
    logic                        w_issue;
    logic                        w_dup;
    logic                        w_off_page;
    logic                        w_adv;

    assign w_stride_sext = {{(vaddr_width_p-stride_width_p){stride_i[stride_width_p-1]}},
                            stride_i};
    assign w_cnt_clamp   = (remaining_iterations_i > max_lp) ? max_lp
                                                             : remaining_iterations_i;

    assign w_idle     = (r_state == e_idle);
    assign w_issue    = (r_state == e_issue);
    assign w_line     = r_addr[vaddr_width_p-1:lg_line_lp];
    assign w_dup      = r_last_v & (w_line == r_last_line);
    assign w_off_page = (r_addr[vaddr_width_p-1:page_offset_width_p] != r_page);

    assign yumi_o     = v_i & w_idle & ~flush_i;
    assign pf_v_o     = w_issue & ~w_dup & ~w_off_page;
    assign pf_vaddr_o = {w_line, {lg_line_lp{1'b0}}};
    assign pf_pc_o    = r_pc;
    assign busy_o     = w_issue;

    // A dup step consumes an iteration without touching the port
    assign w_adv = w_issue & ~w_off_page & ((pf_v_o & pf_ready_and_i) | w_dup);

    always_comb begin
        w_state_n = r_state;
        unique case (r_state)
            e_idle: begin
                if (yumi_o && (w_cnt_clamp != '0)) w_state_n = e_issue;
            end
            e_issue: begin
                if (w_off_page)
                    w_state_n = e_idle;
                else if (w_adv && (r_cnt == output_range_p'(1)))
                    w_state_n = e_idle;
            end
        endcase
        if (flush_i) w_state_n = e_idle;
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state <= e_idle;
        end else begin
            r_state <= w_state_n;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_addr      <= '0;
            r_stride    <= '0;
            r_page      <= '0;
            r_pc        <= '0;
            r_cnt       <= '0;
            r_last_v    <= 1'b0;
            r_last_line <= '0;
        end else begin
            if (yumi_o) begin
                r_addr   <= eff_addr_i + w_stride_sext;
                r_stride <= w_stride_sext;
                r_page   <= eff_addr_i[vaddr_width_p-1:page_offset_width_p];
                r_pc     <= pc_i;
                r_cnt    <= w_cnt_clamp;
                r_last_v <= 1'b0;
            end else if (w_adv) begin
                r_addr <= r_addr + r_stride;
                r_cnt  <= r_cnt - output_range_p'(1);
                if (pf_v_o) begin
                    r_last_line <= w_line;
                    r_last_v    <= 1'b1;
                end
            end
            if (flush_i) r_cnt <= '0;
        end
    end

endmodule

// File: tb/tb_bp_be_stride_prefetch_gen.sv
// Randomized bench for bp_be_stride_prefetch_gen against a per-descriptor
// address-list model, plus directed flush and async-reset sequences.
module tb_bp_be_stride_prefetch_gen;

    logic        clk_i = 1'b0;
    logic        reset_n_i = 1'b0;
    logic        v_i = 1'b0;
    logic [38:0] pc_i = '0;
    logic [38:0] eff_addr_i = '0;
    logic [7:0]  stride_i = '0;
    logic [7:0]  remaining_iterations_i = '0;
    logic        yumi_o;
    logic        flush_i = 1'b0;
    logic        pf_v_o;
    logic [38:0] pf_vaddr_o;
    logic [38:0] pf_pc_o;
    logic        pf_ready_and_i = 1'b1;
    logic        busy_o;

    int          n_cmp = 0;
    int          n_bad = 0;
    bit          rdy_rand = 1'b0;
    logic [38:0] cur_pc = '0;
    logic [38:0] got[$];
    logic [38:0] exp_q[$];
    bit          prev_stall = 1'b0;
    logic [38:0] prev_addr = '0;

    bp_be_stride_prefetch_gen dut (
        .clk_i                  (clk_i),
        .reset_n_i              (reset_n_i),
        .v_i                    (v_i),
        .pc_i                   (pc_i),
        .eff_addr_i             (eff_addr_i),
        .stride_i               (stride_i),
        .remaining_iterations_i (remaining_iterations_i),
        .yumi_o                 (yumi_o),
        .flush_i                (flush_i),
        .pf_v_o                 (pf_v_o),
        .pf_vaddr_o             (pf_vaddr_o),
        .pf_pc_o                (pf_pc_o),
        .pf_ready_and_i         (pf_ready_and_i),
        .busy_o                 (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, obs, exp, $time);
        end
    endtask

    always @(posedge clk_i) begin
        #1;
        pf_ready_and_i = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end

    // Handshake monitor and backpressure stability check
    always @(negedge clk_i) begin
        if (!reset_n_i) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_v", pf_v_o, 1);
                check("stall_addr", pf_vaddr_o, prev_addr);
            end
            if (pf_v_o && pf_ready_and_i) begin
                got.push_back(pf_vaddr_o);
                check("pf_pc", pf_pc_o, cur_pc);
                check("align", pf_vaddr_o[5:0], 0);
            end
            prev_stall = pf_v_o && !pf_ready_and_i && !flush_i;
            prev_addr  = pf_vaddr_o;
        end
    end

    // Address k of the stream is eff + k*stride; stop at the first off-page one
    task automatic model(input logic [38:0] eff, input logic [7:0] str, input logic [7:0] rem);
        int          n;
        logic [38:0] s;
        logic [38:0] a;
        logic [38:0] ln;
        n = (rem > 8'd16) ? 16 : int'(rem);
        s = {{31{str[7]}}, str};
        exp_q.delete();
        for (int k = 1; k <= n; k++) begin
            a = eff + 39'(k) * s;
            if (a[38:12] != eff[38:12]) break;
            ln = {a[38:6], 6'b0};
            if (exp_q.size() == 0 || exp_q[$] != ln) exp_q.push_back(ln);
        end
    endtask

    task automatic wait_idle(input string tag);
        bit done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            if (!busy_o) done = 1'b1;
            else begin
                @(negedge clk_i); #1;
            end
        end
        check(tag, done, 1);
    endtask

    task automatic run_desc(input logic [38:0] eff, input logic [7:0] str,
                            input logic [7:0] rem, input logic [38:0] pc, input bit rnd);
        int base;
        model(eff, str, rem);
        rdy_rand = rnd;
        cur_pc   = pc;
        @(posedge clk_i); #1;
        v_i = 1'b1; pc_i = pc; eff_addr_i = eff;
        stride_i = str; remaining_iterations_i = rem;
        @(negedge clk_i); #1;
        check("yumi", yumi_o, 1);
        base = got.size();
        @(posedge clk_i); #1;
        v_i = 1'b0;
        @(negedge clk_i); #1;
        check("first_v", pf_v_o, exp_q.size() != 0);
        if (exp_q.size() != 0) check("first_addr", pf_vaddr_o, exp_q[0]);
        wait_idle("done");
        check("count", got.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size() && base + i < got.size(); i++)
            check("addr", got[base+i], exp_q[i]);
    endtask

    task automatic flush_test();
        int          base;
        logic [38:0] want [4];
        want = '{39'h5040, 39'h5080, 39'h50C0, 39'h6040};
        rdy_rand = 1'b0;
        cur_pc   = 39'h400;
        @(posedge clk_i); #1;
        v_i = 1'b1; pc_i = 39'h400; eff_addr_i = 39'h5000;
        stride_i = 8'd64; remaining_iterations_i = 8'd8;
        @(negedge clk_i); #1;
        base = got.size();
        @(posedge clk_i); #1;
        v_i = 1'b0;
        for (int i = 0; i < 20 && (got.size() - base) < 2; i++) begin
            @(negedge clk_i); #1;
        end
        @(posedge clk_i); #1;
        flush_i = 1'b1; v_i = 1'b1; pc_i = 39'h800; eff_addr_i = 39'h6000;
        stride_i = 8'd64; remaining_iterations_i = 8'd1;
        @(negedge clk_i); #1;
        check("flush_yumi", yumi_o, 0);
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        cur_pc  = 39'h800;
        @(negedge clk_i); #1;
        check("flush_pfv", pf_v_o, 0);
        check("flush_busy", busy_o, 0);
        check("post_flush_yumi", yumi_o, 1);
        @(posedge clk_i); #1;
        v_i = 1'b0;
        @(negedge clk_i); #1;
        wait_idle("flush_done");
        check("flush_count", got.size() - base, 4);
        for (int i = 0; i < 4 && base + i < got.size(); i++)
            check("flush_addr", got[base+i], want[i]);
    endtask

    task automatic reset_test();
        rdy_rand = 1'b0;
        cur_pc   = 39'h900;
        @(posedge clk_i); #1;
        v_i = 1'b1; pc_i = 39'h900; eff_addr_i = 39'h8000;
        stride_i = 8'd64; remaining_iterations_i = 8'd16;
        @(posedge clk_i); #1;
        v_i = 1'b0;
        repeat (3) @(negedge clk_i);
        #2 reset_n_i = 1'b0;
        #1;
        check("rst_pfv", pf_v_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_vaddr", pf_vaddr_o, 0);
        check("rst_pc", pf_pc_o, 0);
        @(negedge clk_i);
        #2 reset_n_i = 1'b1;
        run_desc(39'h9000, 8'd64, 8'd2, 39'hA00, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [38:0] eff;
        logic [7:0]  str;
        logic [7:0]  rem;
        #12;
        check("reset_pfv", pf_v_o, 0);
        check("reset_vaddr", pf_vaddr_o, 0);
        check("reset_pc", pf_pc_o, 0);
        check("reset_busy", busy_o, 0);
        check("reset_yumi", yumi_o, 0);
        #10 reset_n_i = 1'b1;

        run_desc(39'h1000, 8'd64, 8'd4, 39'h100, 1'b0);
        run_desc(39'h2000, 8'd8, 8'd16, 39'h104, 1'b0);
        run_desc(39'h3040, 8'hC0, 8'd3, 39'h108, 1'b0);
        run_desc(39'h4000, 8'd64, 8'd200, 39'h10C, 1'b1);
        run_desc(39'h7000, 8'd0, 8'd10, 39'h110, 1'b0);
        run_desc(39'h7100, 8'd64, 8'd0, 39'h114, 1'b0);
        flush_test();
        reset_test();

        for (int n = 0; n < 60; n++) begin
            eff = 39'({$urandom, $urandom});
            if ($urandom_range(0, 2) == 0) eff[11:8] = 4'hF;
            str = 8'($urandom);
            rem = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'($urandom_range(0, 20));
            run_desc(eff, str, rem, 39'({$urandom, $urandom}), n[0]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bp_be_stride_prefetch_gen.md
# bp_be_stride_prefetch_gen

Downstream consumer of the backend loop-inference stage. It accepts one loop descriptor per handshake (striding load PC, last effective address, signed byte stride, estimated remaining iterations) and expands it into a stream of cache-line-aligned prefetch virtual addresses. The stream is deduplicated per cache line, bounded to the originating 4 KiB page, and flow-controlled by a valid/ready handshake toward the D$ prefetch port.

## Interface
Parameters
- vaddr_width_p, 39, virtual address width
- stride_width_p, 8, stride width; two's-complement byte stride
- output_range_p, 8, width of the remaining-iterations field
- max_prefetch_p, 16, cap on iterations expanded per descriptor (≤ 2^output_range_p−1)
- block_width_p, 512, cache line width in bits (64 B line, 6 offset bits)
- page_offset_width_p, 12, page offset bits

Ports
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous, active-low reset
- v_i  in  1  descriptor valid
- pc_i  in  vaddr_width_p  striding load PC
- eff_addr_i  in  vaddr_width_p  most recent effective address of the load
- stride_i  in  stride_width_p  signed byte stride
- remaining_iterations_i  in  output_range_p  estimated iterations left
- yumi_o  out  1  descriptor consumed this cycle (= v_i & idle & ~flush_i)
- flush_i  in  1  abandon the current stream (mispredict/exception/fence)
- pf_v_o  out  1  prefetch request valid
- pf_vaddr_o  out  vaddr_width_p  line-aligned prefetch address (low 6 bits zero)
- pf_pc_o  out  vaddr_width_p  PC tag of the stream
- pf_ready_and_i  in  1  prefetch port accepts
- busy_o  out  1  state != IDLE

## Operation
- States: IDLE, ISSUE.
- IDLE: yumi_o = v_i & ~flush_i. On accept, latch:
  - addr_r = eff_addr_i + sext(stride_i), computed modulo 2^vaddr_width_p
  - stride_r = sext(stride_i)
  - page_r = eff_addr_i[vaddr−1:12]
  - pc_r = pc_i
  - cnt_r = min(remaining_iterations_i, max_prefetch_p)
  - last_v_r = 0
- Next state is ISSUE if cnt_r ≠ 0, otherwise IDLE.
- ISSUE, per cycle:
  - line = addr_r[vaddr−1:6]
  - dup = last_v_r & (line == last_line_r)
  - off_page = addr_r[vaddr−1:12] != page_r
- If off_page: go to IDLE. No request is made.
- pf_v_o = ISSUE & ~dup & ~off_page. pf_vaddr_o = {line, 6'b0}.
- The stream advances when (pf_v_o & pf_ready_and_i) | dup. On advance:
  - addr_r += stride_r
  - cnt_r −= 1
  - if a request was issued: last_line_r = line, last_v_r = 1
  - if cnt_r was 1: go to IDLE
- Zero stride: the first line issues, every later step is a dup, so exactly one prefetch is made per descriptor.
- flush_i (any state): next state is IDLE and cnt_r = 0. In IDLE, flush_i wins over v_i, so there is no yumi.
- v_i is not accepted while in ISSUE. Upstream holds v_i until it sees yumi_o.

## Timing
- Reset (async assert, values held while low): state IDLE, cnt_r 0, last_v_r 0, addr_r/pc_r/page_r 0. Resulting outputs: pf_v_o 0, pf_vaddr_o 0, pf_pc_o 0, busy_o 0, yumi_o 0.
- Accept at cycle T. The first pf_v_o can assert at T+1.
- Throughput is 1 request per cycle while pf_ready_and_i = 1. A dup step takes 1 cycle and makes no request.
- Under backpressure, pf_v_o and pf_vaddr_o stay stable until the handshake or a flush.
- flush_i at cycle T: pf_v_o = 0 from T+1. The earliest new yumi_o is at T+1.
- Final advance at T: pf_v_o = 0 at T+1, and yumi_o can assert at T+1.
- off_page detected at T: pf_v_o = 0 at T. Return to IDLE at T+1.
- Reset release mid-stream: the block restarts in IDLE.
- A flush in the same cycle as the final handshake: that request counts as sent, and the block goes to IDLE.

## Test plan
- eff=0x1000, stride=64, rem=4, ready=1 -> pf_vaddr 0x1040, 0x1080, 0x10C0, 0x1100 on T+1..T+4; busy_o=0 at T+5.
- eff=0x2000, stride=8, rem=16 -> exactly 3 requests (0x2000, 0x2040, 0x2080); done at T+16.
- eff=0x3040, stride=0xC0 (−64), rem=3 -> one request 0x3000; 0x2FC0 is off-page, so back to IDLE with no second request.
- rem=200 (clamped to 16), stride=64, ready held low 5 cycles at the 2nd request -> pf_vaddr stays stable at its value; 16 requests total.
- Flush after 2 of 8 requests, with v_i high -> pf_v_o=0 next cycle, no yumi in the flush cycle, yumi_o=1 the cycle after. Also: rem=0 or stride=0 -> 0 requests or 1 request respectively.
- Assert reset_n_i low mid-ISSUE (asynchronously, between edges) -> pf_v_o and busy_o go to 0 immediately; after release, a new descriptor is accepted in the first cycle.
